// File: rtl/sha3_pkg.sv
// Shared Keccak state definitions for the SHA-3 datapath: lane type, state geometry,
// digest lane counts and the lane-index to (row, x) mapping.
package sha3_pkg;

  localparam int unsigned LANE_W         = 64;
  localparam int unsigned STATE_LANES    = 25;
  localparam int unsigned SHA3_256_LANES = 4;
  localparam int unsigned SHA3_512_LANES = 8;

  typedef logic [LANE_W-1:0] lane_t;

  typedef struct packed {
    logic [2:0] row;
    logic [2:0] x;
  } lane_pos_t;

  // Lane i sits at row y = i/5, column x = i%5.
  function automatic lane_pos_t lane_pos(input int unsigned idx);
    lane_pos_t p;
    p.row = 3'(idx / 5);
    p.x   = 3'(idx % 5);
    return p;
  endfunction

endpackage

// File: rtl/sha3_state_dispatch.sv
// Captures a full Keccak state on sample/iready and streams its first OUT_LANES lanes
// as 64-bit words on a valid/ready interface with a last marker.
module sha3_state_dispatch
  import sha3_pkg::*;
#(
  parameter int unsigned OUT_LANES = SHA3_256_LANES
) (
  input  logic  clk,
  input  logic  rst_n,
  input  lane_t isa [5],
  input  lane_t isb [5],
  input  lane_t isc [5],
  input  lane_t isd [5],
  input  lane_t ise [5],
  input  logic  sample,
  output logic  iready,
  output lane_t odata,
  output logic  ovalid,
  output logic  olast,
  input  logic  oready,
  output logic  odropped
);

  if (OUT_LANES < 1 || OUT_LANES > STATE_LANES) begin : g_bad_out_lanes
    $error("sha3_state_dispatch: OUT_LANES must be in 1..25");
  end

  localparam int unsigned      IDX_W    = $clog2(OUT_LANES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_LANES - 1);

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_e;

  state_e           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic             r_dropped;
  lane_t            r_buf [OUT_LANES];
  lane_t            w_lanes [STATE_LANES];
  lane_t            w_odata;
  logic             w_iready, w_capture, w_beat, w_last, w_unused;

  // iready includes rst_n so nothing can be captured while reset is held.
  assign w_iready  = (r_state == S_IDLE) && rst_n;
  assign w_capture = sample && w_iready;
  assign w_beat    = (r_state == S_SEND) && oready;
  assign w_last    = (r_state == S_SEND) && (r_idx == LAST_IDX);

  always_comb begin
    lane_pos_t p;
    p = '0;
    for (int unsigned i = 0; i < STATE_LANES; i++) begin
      p = lane_pos(i);
      case (p.row)
        3'd0:    w_lanes[i] = isa[p.x];
        3'd1:    w_lanes[i] = isb[p.x];
        3'd2:    w_lanes[i] = isc[p.x];
        3'd3:    w_lanes[i] = isd[p.x];
        3'd4:    w_lanes[i] = ise[p.x];
        default: w_lanes[i] = '0;
      endcase
    end
  end

  // Lanes past OUT_LANES are deliberately never stored.
  always_comb begin
    w_unused = 1'b0;
    for (int unsigned i = OUT_LANES; i < STATE_LANES; i++) begin
      w_unused = w_unused ^ (^w_lanes[i]);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (w_capture) begin
          w_state_nxt = S_SEND;
          w_idx_nxt   = '0;
        end
      end
      S_SEND: begin
        if (w_beat) begin
          if (w_last) w_state_nxt = S_IDLE;
          else        w_idx_nxt   = r_idx + IDX_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_dropped <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_dropped <= sample && !w_iready;
    end
  end

  always_ff @(posedge clk) begin
    if (w_capture) begin
      for (int unsigned i = 0; i < OUT_LANES; i++) begin
        r_buf[i] <= w_lanes[i];
      end
    end
  end

  always_comb begin
    w_odata = '0;
    if (r_state == S_SEND) begin
      for (int unsigned i = 0; i < OUT_LANES; i++) begin
        if (r_idx == IDX_W'(i)) w_odata = r_buf[i];
      end
    end
  end

  assign iready   = w_iready;
  assign odata    = w_odata;
  assign ovalid   = (r_state == S_SEND);
  assign olast    = w_last;
  assign odropped = r_dropped;

endmodule

// File: tb/tb_sha3_state_dispatch.sv
// Directed bench for sha3_state_dispatch: vector table on a 4-lane instance plus
// hand sequences for back-to-back (8 lanes), reset mid-stream, and 1/25-lane edges.
module tb_sha3_state_dispatch;
  import sha3_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  lane_t isa [5], isb [5], isc [5], isd [5], ise [5];

  logic  s4 = 1'b0, s8 = 1'b0, s1 = 1'b0, s25 = 1'b0;
  logic  r4 = 1'b0, r8 = 1'b0, r1 = 1'b0, r25 = 1'b0;
  logic  ir4, v4, l4, dr4, ir8, v8, l8, dr8, ir1, v1, l1, dr1, ir25, v25, l25, dr25;
  lane_t d4, d8, d1, d25;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  sha3_state_dispatch #(.OUT_LANES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
    .sample(s4), .iready(ir4), .odata(d4), .ovalid(v4), .olast(l4), .oready(r4), .odropped(dr4));
  sha3_state_dispatch #(.OUT_LANES(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
    .sample(s8), .iready(ir8), .odata(d8), .ovalid(v8), .olast(l8), .oready(r8), .odropped(dr8));
  sha3_state_dispatch #(.OUT_LANES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
    .sample(s1), .iready(ir1), .odata(d1), .ovalid(v1), .olast(l1), .oready(r1), .odropped(dr1));
  sha3_state_dispatch #(.OUT_LANES(25)) u_dut25 (
    .clk(clk), .rst_n(rst_n), .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
    .sample(s25), .iready(ir25), .odata(d25), .ovalid(v25), .olast(l25), .oready(r25), .odropped(dr25));

  typedef struct {
    logic smp;
    logic rdy;
    int   pat;
    logic ev;
    logic el;
    int   lane;
    logic eir;
    logic edr;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string name, input lane_t act, input lane_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Pattern 0: lane i = 0x1111..*i; pattern 1: distinct tag; pattern 2: {seed, i}.
  function automatic lane_t lane_val(input int pat, input int seed, input int i);
    case (pat)
      0:       return 64'h1111_1111_1111_1111 * 64'(i);
      1:       return 64'hA5A5_0000_0000_0000 | (64'(i) << 8) | 64'(i);
      default: return {32'(seed), 32'(i)};
    endcase
  endfunction

  task automatic load(input int pat, input int seed);
    for (int i = 0; i < 25; i++) begin
      case (i / 5)
        0:       isa[i % 5] = lane_val(pat, seed, i);
        1:       isb[i % 5] = lane_val(pat, seed, i);
        2:       isc[i % 5] = lane_val(pat, seed, i);
        3:       isd[i % 5] = lane_val(pat, seed, i);
        default: ise[i % 5] = lane_val(pat, seed, i);
      endcase
    end
  endtask

  function automatic void addv(input logic smp, input logic rdy, input int pat, input logic ev,
                               input logic el, input int lane, input logic eir, input logic edr);
    vec_t v;
    v = '{smp, rdy, pat, ev, el, lane, eir, edr};
    tbl.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    load(0, 0);

    // Reset state, with a sample held during reset that must be neither captured nor flagged.
    s4 = 1'b1;
    repeat (2) @(negedge clk);
    chk1("rst ovalid", v4, 1'b0);
    chk1("rst olast", l4, 1'b0);
    chk1("rst iready", ir4, 1'b0);
    chk1("rst odropped", dr4, 1'b0);
    chk("rst odata", d4, '0);
    s4 = 1'b0;
    rst_n = 1'b1;
    #1 chk1("post-rst iready", ir4, 1'b1);

    //   smp rdy pat ev el lane eir edr
    // Basic
    addv(1, 1, 0, 0, 0, 0, 1, 0);
    addv(0, 1, 0, 1, 0, 0, 0, 0);
    addv(0, 1, 0, 1, 0, 1, 0, 0);
    addv(0, 1, 0, 1, 0, 2, 0, 0);
    addv(0, 1, 0, 1, 1, 3, 0, 0);
    addv(0, 1, 0, 0, 0, 0, 1, 0);
    // Backpressure: oready 1,0,0,1,0,1,1
    addv(1, 1, 0, 0, 0, 0, 1, 0);
    addv(0, 1, 0, 1, 0, 0, 0, 0);
    addv(0, 0, 0, 1, 0, 1, 0, 0);
    addv(0, 0, 0, 1, 0, 1, 0, 0);
    addv(0, 1, 0, 1, 0, 1, 0, 0);
    addv(0, 0, 0, 1, 0, 2, 0, 0);
    addv(0, 1, 0, 1, 0, 2, 0, 0);
    addv(0, 1, 0, 1, 1, 3, 0, 0);
    addv(0, 1, 0, 0, 0, 0, 1, 0);
    // Drop: second state offered one cycle after acceptance
    addv(1, 1, 0, 0, 0, 0, 1, 0);
    addv(1, 1, 1, 1, 0, 0, 0, 0);
    addv(0, 1, 0, 1, 0, 1, 0, 1);
    addv(0, 1, 0, 1, 0, 2, 0, 0);
    addv(0, 1, 0, 1, 1, 3, 0, 0);
    addv(0, 1, 0, 0, 0, 0, 1, 0);

    foreach (tbl[k]) begin
      @(negedge clk);
      load(tbl[k].pat, 0);
      s4 = tbl[k].smp;
      r4 = tbl[k].rdy;
      #1;
      chk1($sformatf("v%0d iready", k), ir4, tbl[k].eir);
      chk1($sformatf("v%0d ovalid", k), v4, tbl[k].ev);
      chk1($sformatf("v%0d olast", k), l4, tbl[k].el);
      chk1($sformatf("v%0d odropped", k), dr4, tbl[k].edr);
      if (tbl[k].ev) chk($sformatf("v%0d odata", k), d4, lane_val(0, 0, tbl[k].lane));
    end
    @(negedge clk);
    s4 = 1'b0;

    // Back-to-back, 8 lanes: accepts every 9 clocks, drops flagged in between.
    r8 = 1'b1;
    for (int c = 0; c < 27; c++) begin
      int ph;
      @(negedge clk);
      load(2, c);
      s8 = 1'b1;
      #1;
      ph = c % 9;
      if (ph == 0) begin
        chk1($sformatf("b2b c%0d ovalid", c), v8, 1'b0);
        chk1($sformatf("b2b c%0d iready", c), ir8, 1'b1);
        chk1($sformatf("b2b c%0d odropped", c), dr8, c > 0);
      end else begin
        chk1($sformatf("b2b c%0d ovalid", c), v8, 1'b1);
        chk($sformatf("b2b c%0d odata", c), d8, lane_val(2, c - ph, ph - 1));
        chk1($sformatf("b2b c%0d olast", c), l8, ph == 8);
        chk1($sformatf("b2b c%0d iready", c), ir8, 1'b0);
        chk1($sformatf("b2b c%0d odropped", c), dr8, ph >= 2);
      end
    end
    @(negedge clk);
    s8 = 1'b0;
    @(negedge clk);

    // Reset after the 2nd beat: outputs must drop without a clock edge.
    @(negedge clk);
    load(0, 0);
    s4 = 1'b1;
    r4 = 1'b1;
    @(negedge clk);
    s4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid lane2 odata", d4, lane_val(0, 0, 2));
    #2 rst_n = 1'b0;
    #1;
    chk1("async ovalid", v4, 1'b0);
    chk1("async olast", l4, 1'b0);
    chk1("async iready", ir4, 1'b0);
    @(negedge clk);
    chk1("held rst ovalid", v4, 1'b0);
    rst_n = 1'b1;
    #1 chk1("after rst iready", ir4, 1'b1);
    load(1, 0);
    s4 = 1'b1;
    @(negedge clk);
    s4 = 1'b0;
    #1;
    chk1("restart ovalid", v4, 1'b1);
    chk("restart odata", d4, lane_val(1, 0, 0));
    chk1("restart olast", l4, 1'b0);
    repeat (4) @(negedge clk);
    #1;
    chk1("restart done ovalid", v4, 1'b0);
    chk1("restart done iready", ir4, 1'b1);

    // Single-lane instance.
    @(negedge clk);
    load(1, 0);
    s1 = 1'b1;
    r1 = 1'b1;
    @(negedge clk);
    s1 = 1'b0;
    #1;
    chk1("ol1 ovalid", v1, 1'b1);
    chk1("ol1 olast", l1, 1'b1);
    chk("ol1 odata", d1, lane_val(1, 0, 0));
    @(negedge clk);
    #1;
    chk1("ol1 ovalid off", v1, 1'b0);
    chk1("ol1 olast off", l1, 1'b0);
    chk1("ol1 iready", ir1, 1'b1);

    // Full-state instance: lane 24 (ise[4]) carries olast.
    @(negedge clk);
    load(2, 77);
    s25 = 1'b1;
    r25 = 1'b1;
    @(negedge clk);
    s25 = 1'b0;
    for (int i = 0; i < 25; i++) begin
      #1;
      chk1($sformatf("ol25 l%0d ovalid", i), v25, 1'b1);
      chk($sformatf("ol25 l%0d odata", i), d25, lane_val(2, 77, i));
      chk1($sformatf("ol25 l%0d olast", i), l25, i == 24);
      @(negedge clk);
    end
    #1;
    chk1("ol25 ovalid off", v25, 1'b0);
    chk1("ol25 iready", ir25, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
